// File: rtl/boot_ctrl_pkg.sv
// Shared definitions for the boot-decision controller: FSM state encoding
// (also driven out on ctrl_state for LEDs/debug) and the DFU state codes
// the controller reacts to.
package boot_ctrl_pkg;

  localparam int CTRL_STATE_W = 3;

  typedef enum logic [CTRL_STATE_W-1:0] {
    STARTUP  = 3'd0,
    DFU_HOLD = 3'd1,
    BOOT_REQ = 3'd2,
    BOOTED   = 3'd3
  } ctrl_state_t;

  // DFU core state codes
  localparam logic [7:0] DFU_APP_IDLE = 8'h00;
  localparam logic [7:0] DFU_IDLE     = 8'h02;

endpackage

// File: rtl/boot_debounce.sv
// Boot button qualifier: two-flop synchroniser followed by a stable-count
// debounce. dout only takes the synchronised level after it has differed
// from dout for DEBOUNCE_CYCLES consecutive samples, so a stable pin edge
// reaches dout 2 + DEBOUNCE_CYCLES cycles later.
module boot_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] stable_cnt;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive samples that disagree with dout; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_cnt <= '0;
      dout       <= 1'b0;
    end else if (sync_q2 == dout) begin
      stable_cnt <= '0;
    end else if (stable_cnt == LAST) begin
      dout       <= sync_q2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/boot_ctrl.sv
// Boot-decision controller between the USB DFU core and the ICAPE2 warm-boot
// sequencer. After the startup delay it either holds in the bootloader
// (button pressed) or requests a warm boot; from the bootloader a DFU detach
// or an idle timeout also requests the boot.
//
// Handshake: boot_req is a registered level raised on entry to BOOT_REQ and
// held until boot_ack is sampled high in that state; the request drops on the
// following edge and the controller parks in BOOTED until reset. boot_ack seen
// in any other state has no effect.
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES      = 65535,
  parameter int unsigned DEBOUNCE_CYCLES     = 4096,
  parameter int unsigned IDLE_TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W               = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_locked,
  input  logic                    boot_button,
  input  logic [7:0]              dfu_state,
  input  logic                    dfu_detach,
  input  logic                    boot_ack,
  output logic                    boot_req,
  output logic                    user_bootmode,
  output logic [CTRL_STATE_W-1:0] ctrl_state
);

  // The startup counter counts locked cycles up from zero; the decision is
  // taken once STARTUP_CYCLES locked cycles have elapsed (equivalent to a
  // down-counter reaching zero, but it clears to zero on reset like the rest).
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES);
  localparam bit               TIMEOUT_EN   = (IDLE_TIMEOUT_CYCLES != 0);
  localparam int unsigned      IDLE_LAST_I  = TIMEOUT_EN ? (IDLE_TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] IDLE_LAST    = CNT_W'(IDLE_LAST_I);

  ctrl_state_t      state;
  logic [CNT_W-1:0] startup_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic             btn_db;
  logic             idle_expired;
  logic             stay_in_dfu;

  boot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (boot_button),
    .dout (btn_db)
  );

  // Timeout fires on the sample that completes the run of dfuIDLE cycles.
  assign idle_expired = TIMEOUT_EN && (dfu_state == DFU_IDLE) && (idle_cnt == IDLE_LAST);
  // A button qualified on the very decision cycle still counts as a request to stay.
  assign stay_in_dfu  = user_bootmode || btn_db;
  assign ctrl_state   = state;

  // Boot-decision FSM with its counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= STARTUP;
      boot_req      <= 1'b0;
      user_bootmode <= 1'b0;
      startup_cnt   <= '0;
      idle_cnt      <= '0;
    end else begin
      case (state)
        STARTUP: begin
          if (btn_db) begin
            user_bootmode <= 1'b1;
          end
          if (!clk_locked) begin
            startup_cnt <= '0;
          end else if (startup_cnt == STARTUP_LAST) begin
            if (stay_in_dfu) begin
              state <= DFU_HOLD;
            end else begin
              state    <= BOOT_REQ;
              boot_req <= 1'b1;
            end
          end else begin
            startup_cnt <= startup_cnt + CNT_W'(1);
          end
        end
        DFU_HOLD: begin
          // Detach beats any button activity; the button is not looked at here.
          if (dfu_detach || idle_expired) begin
            user_bootmode <= 1'b0;
            idle_cnt      <= '0;
            state         <= BOOT_REQ;
            boot_req      <= 1'b1;
          end else if (dfu_state == DFU_IDLE) begin
            if (idle_cnt != '1) begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        BOOT_REQ: begin
          if (boot_ack) begin
            boot_req <= 1'b0;
            state    <= BOOTED;
          end
        end
        BOOTED: begin
          boot_req <= 1'b0;
        end
        default: begin
          state    <= STARTUP;
          boot_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// Bench for boot_ctrl: directed scenarios for each behaviour plus randomized
// input timelines checked cycle by cycle against an event-time reference model.
module tb_boot_ctrl;
  import boot_ctrl_pkg::*;

  localparam int STARTUP = 16;
  localparam int DEB     = 4;
  localparam int IDLE_TO = 100;
  localparam int H       = 320;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_locked = 1'b0;
  logic       boot_button = 1'b0;
  logic [7:0] dfu_state = DFU_APP_IDLE;
  logic       dfu_detach = 1'b0;
  logic       boot_ack = 1'b0;
  logic       boot_req;
  logic       user_bootmode;
  logic [2:0] ctrl_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Randomized input timelines, index t = value sampled at edge t after reset release.
  bit         lock_a [0:H];
  bit         pin_a  [0:H];
  bit         det_a  [0:H];
  bit         ack_a  [0:H];
  logic [7:0] dfu_a  [0:H];

  boot_ctrl #(
    .STARTUP_CYCLES     (STARTUP),
    .DEBOUNCE_CYCLES    (DEB),
    .IDLE_TIMEOUT_CYCLES(IDLE_TO),
    .CNT_W              (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_locked   (clk_locked),
    .boot_button  (boot_button),
    .dfu_state    (dfu_state),
    .dfu_detach   (dfu_detach),
    .boot_ack     (boot_ack),
    .boot_req     (boot_req),
    .user_bootmode(user_bootmode),
    .ctrl_state   (ctrl_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One active edge, then settle to the falling edge where outputs are sampled.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Reset with idle inputs; release on a falling edge so the next rising edge is edge 1.
  task automatic apply_reset();
    @(negedge clk);
    reset       = 1'b0;
    clk_locked  = 1'b0;
    boot_button = 1'b0;
    dfu_state   = DFU_APP_IDLE;
    dfu_detach  = 1'b0;
    boot_ack    = 1'b0;
    step(3);
    reset = 1'b1;
  endtask

  // Press the button through startup and wait (bounded) for the bootloader hold.
  task automatic enter_hold(output bit ok);
    apply_reset();
    clk_locked  = 1'b1;
    boot_button = 1'b1;
    step(10);
    boot_button = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ctrl_state == 3'd1) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    clk_locked = 1'b1;
    step(2);
    n_cmp++; if (boot_req !== 1'b0) begin n_fail++; $display("FAIL rst_boot_req: got %b want 0", boot_req); end
    n_cmp++; if (user_bootmode !== 1'b0) begin n_fail++; $display("FAIL rst_bootmode: got %b want 0", user_bootmode); end
    n_cmp++; if (ctrl_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", ctrl_state); end
  endtask

  task automatic test_normal_boot();
    apply_reset();
    clk_locked = 1'b1;
    step(16);
    n_cmp++; if (boot_req !== 1'b0 || ctrl_state !== 3'd0) begin n_fail++; $display("FAIL norm_pre_edge16: req=%b state=%0d want 0/0", boot_req, ctrl_state); end
    step(1);
    n_cmp++; if (boot_req !== 1'b1 || ctrl_state !== 3'd2) begin n_fail++; $display("FAIL norm_rise_edge17: req=%b state=%0d want 1/2", boot_req, ctrl_state); end
    step(2);
    n_cmp++; if (boot_req !== 1'b1) begin n_fail++; $display("FAIL norm_held: req=%b want 1", boot_req); end
    boot_ack = 1'b1;
    step(1);
    boot_ack = 1'b0;
    n_cmp++; if (boot_req !== 1'b0 || ctrl_state !== 3'd3) begin n_fail++; $display("FAIL norm_ack: req=%b state=%0d want 0/3", boot_req, ctrl_state); end
    boot_ack = 1'b1;
    step(1);
    boot_ack = 1'b0;
    step(2);
    n_cmp++; if (boot_req !== 1'b0 || ctrl_state !== 3'd3) begin n_fail++; $display("FAIL norm_booted_ack_ignored: req=%b state=%0d want 0/3", boot_req, ctrl_state); end
  endtask

  task automatic test_button_after_startup();
    apply_reset();
    clk_locked = 1'b1;
    step(17);
    boot_button = 1'b1;
    step(12);
    boot_button = 1'b0;
    n_cmp++; if (ctrl_state !== 3'd2 || user_bootmode !== 1'b0 || boot_req !== 1'b1) begin
      n_fail++; $display("FAIL late_button: state=%0d ub=%b req=%b want 2/0/1", ctrl_state, user_bootmode, boot_req);
    end
  endtask

  task automatic test_glitch_startup();
    apply_reset();
    clk_locked = 1'b1;
    step(2);
    boot_button = 1'b1;       // DEB-1 cycle glitch
    step(DEB - 1);
    boot_button = 1'b0;
    step(8);
    n_cmp++; if (user_bootmode !== 1'b0) begin n_fail++; $display("FAIL glitch_ub: got %b want 0", user_bootmode); end
    step(17 - 2 - (DEB - 1) - 8);
    n_cmp++; if (ctrl_state !== 3'd2 || boot_req !== 1'b1) begin n_fail++; $display("FAIL glitch_boot: state=%0d req=%b want 2/1", ctrl_state, boot_req); end
  endtask

  task automatic test_button_hold();
    bit bad;
    apply_reset();
    clk_locked  = 1'b1;
    boot_button = 1'b1;
    step(6);
    n_cmp++; if (user_bootmode !== 1'b0) begin n_fail++; $display("FAIL hold_ub_edge6: got %b want 0", user_bootmode); end
    step(1);
    n_cmp++; if (user_bootmode !== 1'b1) begin n_fail++; $display("FAIL hold_ub_edge7: got %b want 1", user_bootmode); end
    step(3);
    boot_button = 1'b0;
    step(6);
    n_cmp++; if (ctrl_state !== 3'd0) begin n_fail++; $display("FAIL hold_state_edge16: got %0d want 0", ctrl_state); end
    step(1);
    n_cmp++; if (ctrl_state !== 3'd1 || boot_req !== 1'b0) begin n_fail++; $display("FAIL hold_state_edge17: state=%0d req=%b want 1/0", ctrl_state, boot_req); end
    dfu_state = 8'h05;
    bad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (boot_req !== 1'b0 || ctrl_state !== 3'd1 || user_bootmode !== 1'b1) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL hold_1000: req=%b state=%0d ub=%b want 0/1/1 throughout", boot_req, ctrl_state, user_bootmode); end
  endtask

  task automatic test_detach_glitch();
    bit ok;
    enter_hold(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL detach_enter_hold: state=%0d want 1", ctrl_state); end
    dfu_state   = 8'h05;
    dfu_detach  = 1'b1;
    boot_button = 1'b1;
    step(1);
    dfu_detach = 1'b0;
    n_cmp++; if (boot_req !== 1'b1 || user_bootmode !== 1'b0 || ctrl_state !== 3'd2) begin
      n_fail++; $display("FAIL detach_wins: req=%b ub=%b state=%0d want 1/0/2", boot_req, user_bootmode, ctrl_state);
    end
    step(1);
    boot_button = 1'b0;
    step(10);
    n_cmp++; if (user_bootmode !== 1'b0 || ctrl_state !== 3'd2 || boot_req !== 1'b1) begin
      n_fail++; $display("FAIL detach_after_glitch: ub=%b state=%0d req=%b want 0/2/1", user_bootmode, ctrl_state, boot_req);
    end
  endtask

  task automatic test_idle_timeout();
    bit ok;
    enter_hold(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL idle_enter_hold: state=%0d want 1", ctrl_state); end
    dfu_state = DFU_IDLE;
    step(99);
    dfu_state = 8'h05;
    step(1);
    dfu_state = DFU_IDLE;
    n_cmp++; if (boot_req !== 1'b0 || ctrl_state !== 3'd1) begin n_fail++; $display("FAIL idle_broken_run: req=%b state=%0d want 0/1", boot_req, ctrl_state); end
    step(99);
    n_cmp++; if (boot_req !== 1'b0 || ctrl_state !== 3'd1) begin n_fail++; $display("FAIL idle_99: req=%b state=%0d want 0/1", boot_req, ctrl_state); end
    step(1);
    n_cmp++; if (boot_req !== 1'b1 || user_bootmode !== 1'b0 || ctrl_state !== 3'd2) begin
      n_fail++; $display("FAIL idle_100: req=%b ub=%b state=%0d want 1/0/2", boot_req, user_bootmode, ctrl_state);
    end
    dfu_state = DFU_APP_IDLE;
  endtask

  task automatic test_relock();
    apply_reset();
    clk_locked = 1'b1;
    step(9);
    clk_locked = 1'b0;
    step(2);
    clk_locked = 1'b1;
    step(16);
    n_cmp++; if (boot_req !== 1'b0 || ctrl_state !== 3'd0) begin n_fail++; $display("FAIL relock_pre: req=%b state=%0d want 0/0", boot_req, ctrl_state); end
    step(1);
    n_cmp++; if (boot_req !== 1'b1) begin n_fail++; $display("FAIL relock_rise: req=%b want 1", boot_req); end
    clk_locked = 1'b0;
    step(3);
    clk_locked = 1'b1;
    n_cmp++; if (boot_req !== 1'b1 || ctrl_state !== 3'd2) begin n_fail++; $display("FAIL late_unlock: req=%b state=%0d want 1/2", boot_req, ctrl_state); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    clk_locked = 1'b1;
    step(17);
    n_cmp++; if (boot_req !== 1'b1) begin n_fail++; $display("FAIL areset_pre: req=%b want 1", boot_req); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (boot_req !== 1'b0 || ctrl_state !== 3'd0 || user_bootmode !== 1'b0) begin
      n_fail++; $display("FAIL areset_immediate: req=%b state=%0d ub=%b want 0/0/0", boot_req, ctrl_state, user_bootmode);
    end
    @(negedge clk);
    reset = 1'b1;
    step(16);
    n_cmp++; if (boot_req !== 1'b0) begin n_fail++; $display("FAIL areset_restart_pre: req=%b want 0", boot_req); end
    step(1);
    n_cmp++; if (boot_req !== 1'b1) begin n_fail++; $display("FAIL areset_restart_rise: req=%b want 1", boot_req); end
  endtask

  task automatic test_ack_held();
    apply_reset();
    clk_locked = 1'b1;
    boot_ack   = 1'b1;
    step(17);
    n_cmp++; if (boot_req !== 1'b1 || ctrl_state !== 3'd2) begin n_fail++; $display("FAIL ackheld_entry: req=%b state=%0d want 1/2", boot_req, ctrl_state); end
    step(1);
    n_cmp++; if (boot_req !== 1'b0 || ctrl_state !== 3'd3) begin n_fail++; $display("FAIL ackheld_done: req=%b state=%0d want 0/3", boot_req, ctrl_state); end
    boot_ack = 1'b0;
  endtask

  // Random timelines; expected outputs derived from event times computed over the arrays.
  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      int lk, ds, dl, bs, bl, brk_div, det_div, ack_div;
      int d, k, e, r, a, run;
      bit hold;
      bit exp_req, exp_ub;
      logic [2:0] exp_st;

      lk = $urandom_range(1, 6);
      for (int t = 0; t <= H; t++) begin
        lock_a[t] = (t >= lk);
        pin_a[t]  = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        ds = $urandom_range(lk + 1, lk + 14);
        dl = $urandom_range(1, 3);
        for (int t = ds; t < ds + dl; t++) lock_a[t] = 1'b0;
      end
      for (int t = 60; t <= H; t++) lock_a[t] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        bs = $urandom_range(1, 40);
        bl = $urandom_range(1, 8);
        for (int t = bs; t < bs + bl; t++) pin_a[t] = 1'b1;
      end
      for (int t = 60; t <= H; t++) pin_a[t] = ($urandom_range(0, 4) == 0);
      brk_div = $urandom_range(60, 400);
      det_div = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(40, 300);
      ack_div = $urandom_range(1, 6);
      for (int t = 0; t <= H; t++) begin
        dfu_a[t] = ($urandom_range(1, brk_div) == 1) ? 8'h05 : DFU_IDLE;
        det_a[t] = (det_div != 0) && ($urandom_range(1, det_div) == 1);
        ack_a[t] = ($urandom_range(1, ack_div) == 1);
      end

      // Decision edge: STARTUP+1 consecutive locked samples.
      d = -1; run = 0;
      for (int t = 1; t <= H; t++) begin
        run = lock_a[t] ? run + 1 : 0;
        if (d < 0 && run == STARTUP + 1) d = t;
      end
      // First debounced rise: DEB consecutive high pin samples ending two edges earlier.
      k = -1; run = 0;
      for (int t = 2; t <= H; t++) begin
        run = pin_a[t-2] ? run + 1 : 0;
        if (k < 0 && run == DEB) k = t;
      end
      hold = (k > 0) && (d > 0) && (k <= d - 1);
      // Exit from the bootloader hold: detach, or IDLE_TO consecutive dfuIDLE samples.
      e = -1;
      if (hold) begin
        run = 0;
        for (int t = d + 1; t <= H; t++) begin
          run = (dfu_a[t] == DFU_IDLE) ? run + 1 : 0;
          if (e < 0 && (det_a[t] || run == IDLE_TO)) e = t;
        end
      end
      r = hold ? e : d;
      a = -1;
      if (r > 0) begin
        for (int t = r + 1; t <= H; t++) if (a < 0 && ack_a[t]) a = t;
      end

      apply_reset();
      for (int t = 1; t <= H; t++) begin
        clk_locked  = lock_a[t];
        boot_button = pin_a[t];
        dfu_state   = dfu_a[t];
        dfu_detach  = det_a[t];
        boot_ack    = ack_a[t];
        step(1);
        exp_req = (r > 0) && (t >= r) && (a < 0 || t < a);
        exp_ub  = hold && (t >= k + 1) && (e < 0 || t < e);
        if (d < 0 || t < d)                exp_st = 3'd0;
        else if (a > 0 && t >= a)          exp_st = 3'd3;
        else if (r > 0 && t >= r)          exp_st = 3'd2;
        else                               exp_st = 3'd1;
        n_cmp++; if (boot_req !== exp_req) begin n_fail++; $display("FAIL rnd_req it=%0d t=%0d: got %b want %b", it, t, boot_req, exp_req); end
        n_cmp++; if (user_bootmode !== exp_ub) begin n_fail++; $display("FAIL rnd_ub it=%0d t=%0d: got %b want %b", it, t, user_bootmode, exp_ub); end
        n_cmp++; if (ctrl_state !== exp_st) begin n_fail++; $display("FAIL rnd_state it=%0d t=%0d: got %0d want %0d", it, t, ctrl_state, exp_st); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_normal_boot();
    test_button_after_startup();
    test_glitch_startup();
    test_button_hold();
    test_detach_glitch();
    test_idle_timeout();
    test_relock();
    test_async_reset();
    test_ack_held();
    test_random(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
